// File: rtl/itch_replace_decoder_wide_if.sv
// Beat stream in, decoded replace-order fields out.
// Shared by the wide 'U' decoder and its producer/consumer.
interface itch_replace_decoder_wide_if #(
    parameter int LANES = 4
);
    logic [8*LANES-1:0] data_in;
    logic               valid_in;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        old_order_ref;
    logic [63:0]        new_order_ref;
    logic [31:0]        shares;
    logic [31:0]        price;
    logic               packet_invalid;
    logic [15:0]        replace_count;

    modport master (
        output data_in, valid_in, out_ready,
        input  in_ready, out_valid,
        input  old_order_ref, new_order_ref,
        input  shares, price,
        input  packet_invalid, replace_count
    );

    modport slave (
        input  data_in, valid_in, out_ready,
        output in_ready, out_valid,
        output old_order_ref, new_order_ref,
        output shares, price,
        output packet_invalid, replace_count
    );
endinterface

// File: rtl/itch_replace_decoder_wide.sv
// Multi-lane ITCH replace-order ('U') extractor.
// Walks message boundaries lane by lane and holds each decoded 'U'.
module itch_replace_decoder_wide #(
    parameter int         LANES      = 4,
    parameter logic [7:0] MSG_TYPE   = 8'h55,
    parameter int         MSG_LENGTH = 27,
    parameter int         MAX_GAP    = 4
) (
    input logic clk,
    input logic rst,
    itch_replace_decoder_wide_if.slave bus
);
    localparam int         NSTG    = 24;
    localparam logic [3:0] GAP_LIM = 4'(MAX_GAP);
    localparam logic [5:0] U_LEN   = 6'(MSG_LENGTH);

    logic [5:0] remaining, rem_c;
    logic       in_u, u_c;
    logic [4:0] pos, pos_c;
    logic [3:0] gap;
    logic [7:0] stg   [NSTG];
    logic [7:0] stg_c [NSTG];
    logic [7:0] fin_c [NSTG];
    logic [7:0] lane;
    logic       done_c;
    logic       accept;
    logic       idle_tick;
    logic       abort;
    logic [63:0] old_c, new_c;
    logic [31:0] shares_c, price_c;

    function automatic logic [5:0] itch_length(input logic [7:0] t);
        if (t == MSG_TYPE) return U_LEN;
        case (t)
            8'h41:   return 6'd36;
            8'h58:   return 6'd23;
            8'h44:   return 6'd9;
            8'h45:   return 6'd30;
            8'h50:   return 6'd40;
            default: return 6'd2;
        endcase
    endfunction

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.valid_in && bus.in_ready;
    assign idle_tick    = !bus.valid_in && (remaining != 6'd0);
    assign abort        = idle_tick && ((gap + 4'd1) == GAP_LIM);

    // Lane chain; fin_c snapshots staging at the completing lane so a
    // 'U' starting later in the same beat cannot corrupt the result.
    always_comb begin
        rem_c  = remaining;
        u_c    = in_u;
        pos_c  = pos;
        stg_c  = stg;
        fin_c  = stg;
        done_c = 1'b0;
        lane   = 8'h00;
        for (int k = 0; k < LANES; k++) begin
            lane = bus.data_in[8*k +: 8];
            if (rem_c == 6'd0) begin
                rem_c = itch_length(lane) - 6'd1;
                u_c   = (lane == MSG_TYPE);
                pos_c = u_c ? 5'd1 : 5'd0;
            end else begin
                rem_c = rem_c - 6'd1;
                if (u_c) begin
                    if (pos_c != 5'd0 && pos_c <= 5'd24)
                        stg_c[pos_c - 5'd1] = lane;
                    if (rem_c == 6'd0) begin
                        done_c = 1'b1;
                        fin_c  = stg_c;
                    end
                    pos_c = pos_c + 5'd1;
                end
            end
        end
    end

    always_comb begin
        old_c    = '0;
        new_c    = '0;
        shares_c = '0;
        price_c  = '0;
        for (int i = 0; i < 8; i++) begin
            old_c[63-8*i -: 8] = fin_c[i];
            new_c[63-8*i -: 8] = fin_c[8+i];
        end
        for (int i = 0; i < 4; i++) begin
            shares_c[31-8*i -: 8] = fin_c[16+i];
            price_c[31-8*i -: 8]  = fin_c[20+i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining          <= '0;
            in_u               <= 1'b0;
            pos                <= '0;
            gap                <= '0;
            for (int i = 0; i < NSTG; i++) stg[i] <= '0;
            bus.out_valid      <= 1'b0;
            bus.packet_invalid <= 1'b0;
            bus.replace_count  <= '0;
            bus.old_order_ref  <= '0;
            bus.new_order_ref  <= '0;
            bus.shares         <= '0;
            bus.price          <= '0;
        end else begin
            bus.packet_invalid <= 1'b0;
            if (accept) begin
                remaining <= rem_c;
                in_u      <= u_c;
                pos       <= pos_c;
                gap       <= '0;
                stg       <= stg_c;
            end else if (abort) begin
                remaining          <= '0;
                in_u               <= 1'b0;
                pos                <= '0;
                gap                <= '0;
                bus.packet_invalid <= in_u;
            end else if (idle_tick) begin
                gap <= gap + 4'd1;
            end
            if (accept && done_c) begin
                bus.out_valid     <= 1'b1;
                bus.old_order_ref <= old_c;
                bus.new_order_ref <= new_c;
                bus.shares        <= shares_c;
                bus.price         <= price_c;
                bus.replace_count <= bus.replace_count + 16'd1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_itch_replace_decoder_wide.sv
// Directed bench for the wide 'U' decoder.
// Runs a 4-lane and an 8-lane instance side by side.
module tb_itch_replace_decoder_wide;
    typedef logic [7:0] bq_t[$];

    localparam logic [63:0] U1_OLD = 64'h0102030405060708;
    localparam logic [63:0] U1_NEW = 64'h1112131415161718;
    localparam logic [31:0] U1_SH  = 32'h00000064;
    localparam logic [31:0] U1_PR  = 32'h000F4240;
    localparam logic [63:0] U2_OLD = 64'h2122232425262728;
    localparam logic [63:0] U2_NEW = 64'h3132333435363738;
    localparam logic [31:0] U2_SH  = 32'h000001F4;
    localparam logic [31:0] U2_PR  = 32'h00000064;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;

    int   nv4, vb4, npi4;
    int   first8, sec8, stalls8, npi8;
    logic [63:0] c_old, c_new;
    logic [31:0] c_sh, c_pr;

    always #5 clk = ~clk;

    itch_replace_decoder_wide_if #(.LANES(4)) b4 ();
    itch_replace_decoder_wide_if #(.LANES(8)) b8 ();

    itch_replace_decoder_wide #(.LANES(4), .MAX_GAP(4)) u4 (
        .clk(clk), .rst(rst), .bus(b4)
    );
    itch_replace_decoder_wide #(.LANES(8), .MAX_GAP(2)) u8 (
        .clk(clk), .rst(rst), .bus(b8)
    );

    function automatic bq_t make_u(input logic [63:0] o, input logic [63:0] n,
                                   input logic [31:0] s, input logic [31:0] p);
        bq_t q;
        q.push_back(8'h55);
        for (int i = 0; i < 8; i++) q.push_back(o[63-8*i -: 8]);
        for (int i = 0; i < 8; i++) q.push_back(n[63-8*i -: 8]);
        for (int i = 0; i < 4; i++) q.push_back(s[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) q.push_back(p[31-8*i -: 8]);
        q.push_back(8'h00);
        q.push_back(8'h00);
        return q;
    endfunction

    function automatic bq_t make_msg(input logic [7:0] t, input int len);
        bq_t q;
        q.push_back(t);
        for (int i = 1; i < len; i++) q.push_back(8'h55);
        return q;
    endfunction

    function automatic bq_t cat(input bq_t a, input bq_t b);
        bq_t q;
        q = a;
        foreach (b[i]) q.push_back(b[i]);
        return q;
    endfunction

    function automatic bq_t zeros(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'h00);
        return q;
    endfunction

    function automatic logic [63:0] pack(input bq_t q, input int b, input int lanes);
        logic [63:0] d;
        d = '0;
        for (int l = 0; l < lanes; l++)
            if (b*lanes + l < q.size()) d[8*l +: 8] = q[b*lanes + l];
        return d;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        b4.valid_in = 1'b0; b4.out_ready = 1'b1; b4.data_in = '0;
        b8.valid_in = 1'b0; b8.out_ready = 1'b1; b8.data_in = '0;
        @(negedge clk);
        rst = 1'b1;
        nv4 = 0; vb4 = -1; npi4 = 0; npi8 = 0;
    endtask

    task automatic send4(input bq_t q);
        logic [63:0] w;
        int n;
        n = (q.size() + 3) / 4;
        for (int b = 0; b < n; b++) begin
            w = pack(q, b, 4);
            @(negedge clk);
            b4.data_in  = w[31:0];
            b4.valid_in = 1'b1;
            @(posedge clk);
            #1;
            if (b4.out_valid) begin
                nv4++; vb4 = b;
                c_old = b4.old_order_ref; c_new = b4.new_order_ref;
                c_sh = b4.shares; c_pr = b4.price;
            end
            if (b4.packet_invalid) npi4++;
        end
        b4.valid_in = 1'b0;
    endtask

    task automatic send8(input bq_t q, input bit hold, input logic [63:0] hold_old);
        logic [63:0] w;
        int n, bi, c;
        bit acc, pv;
        n = (q.size() + 7) / 8;
        bi = 0; c = 0; pv = 1'b0;
        first8 = -1; sec8 = -1; stalls8 = 0;
        while (bi < n && c < 64) begin
            w = pack(q, bi, 8);
            @(negedge clk);
            b8.data_in   = w;
            b8.valid_in  = 1'b1;
            b8.out_ready = !hold || (first8 >= 0 && c >= first8 + 5);
            #1;
            acc = b8.in_ready;
            if (!acc) stalls8++;
            @(posedge clk);
            #1;
            if (acc) bi++;
            if (b8.packet_invalid) npi8++;
            if (b8.out_valid && !pv) begin
                if (first8 < 0) first8 = c; else sec8 = c;
                c_old = b8.old_order_ref; c_new = b8.new_order_ref;
                c_sh = b8.shares; c_pr = b8.price;
            end
            if (b8.out_valid && !b8.out_ready) begin
                checks++;
                if (b8.old_order_ref !== hold_old)
                    $display("FAIL held_old c=%0d got %h want %h", c, b8.old_order_ref, hold_old);
                else passed++;
            end
            pv = b8.out_valid;
            c++;
        end
        checks++;
        if (bi != n) $display("FAIL send8_timeout beats %0d want %0d", bi, n); else passed++;
        b8.valid_in  = 1'b0;
        b8.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge clk);
        #1;
        checks++; if (b4.out_valid !== 1'b0) $display("FAIL rst_valid4 got %b want 0", b4.out_valid); else passed++;
        checks++; if (b4.in_ready !== 1'b1) $display("FAIL rst_ready4 got %b want 1", b4.in_ready); else passed++;
        checks++; if (b4.replace_count !== 16'd0) $display("FAIL rst_cnt4 got %0d want 0", b4.replace_count); else passed++;
        checks++; if (b4.old_order_ref !== 64'd0) $display("FAIL rst_old4 got %h want 0", b4.old_order_ref); else passed++;
        checks++; if (b4.packet_invalid !== 1'b0) $display("FAIL rst_pi4 got %b want 0", b4.packet_invalid); else passed++;
        checks++; if (b8.out_valid !== 1'b0) $display("FAIL rst_valid8 got %b want 0", b8.out_valid); else passed++;
        checks++; if (b8.price !== 32'd0) $display("FAIL rst_price8 got %h want 0", b8.price); else passed++;
    endtask

    task automatic test_single_u();
        apply_reset();
        send4(cat(make_u(U1_OLD, U1_NEW, U1_SH, U1_PR), zeros(1)));
        checks++; if (nv4 != 1) $display("FAIL t1_nvalid got %0d want 1", nv4); else passed++;
        checks++; if (vb4 != 6) $display("FAIL t1_beat got %0d want 6", vb4); else passed++;
        checks++; if (c_old !== U1_OLD) $display("FAIL t1_old got %h want %h", c_old, U1_OLD); else passed++;
        checks++; if (c_new !== U1_NEW) $display("FAIL t1_new got %h want %h", c_new, U1_NEW); else passed++;
        checks++; if (c_sh !== U1_SH) $display("FAIL t1_shares got %h want %h", c_sh, U1_SH); else passed++;
        checks++; if (c_pr !== U1_PR) $display("FAIL t1_price got %h want %h", c_pr, U1_PR); else passed++;
        checks++; if (b4.replace_count !== 16'd1) $display("FAIL t1_cnt got %0d want 1", b4.replace_count); else passed++;
        @(posedge clk);
        #1;
        checks++; if (b4.out_valid !== 1'b0) $display("FAIL t1_drop got %b want 0", b4.out_valid); else passed++;
    endtask

    task automatic test_mixed();
        bq_t q;
        apply_reset();
        q = cat(cat(make_msg(8'h44, 9), make_u(U2_OLD, U2_NEW, U2_SH, U2_PR)), make_msg(8'h41, 36));
        send4(q);
        checks++; if (nv4 != 1) $display("FAIL t2_nvalid got %0d want 1", nv4); else passed++;
        checks++; if (vb4 != 8) $display("FAIL t2_beat got %0d want 8", vb4); else passed++;
        checks++; if (c_old !== U2_OLD) $display("FAIL t2_old got %h want %h", c_old, U2_OLD); else passed++;
        checks++; if (c_new !== U2_NEW) $display("FAIL t2_new got %h want %h", c_new, U2_NEW); else passed++;
        checks++; if (c_sh !== U2_SH) $display("FAIL t2_shares got %h want %h", c_sh, U2_SH); else passed++;
        checks++; if (npi4 != 0) $display("FAIL t2_pi got %0d want 0", npi4); else passed++;
        nv4 = 0; vb4 = -1;
        send4(cat(make_u(U1_OLD, U1_NEW, U1_SH, U1_PR), zeros(1)));
        checks++; if (vb4 != 6) $display("FAIL t2_after_a_beat got %0d want 6", vb4); else passed++;
        checks++; if (c_pr !== U1_PR) $display("FAIL t2_after_a_price got %h want %h", c_pr, U1_PR); else passed++;
        checks++; if (b4.replace_count !== 16'd2) $display("FAIL t2_cnt got %0d want 2", b4.replace_count); else passed++;
    endtask

    task automatic test_gap_abort();
        bq_t u, q;
        apply_reset();
        u = make_u(U1_OLD, U1_NEW, U1_SH, U1_PR);
        for (int i = 0; i < 12; i++) q.push_back(u[i]);
        send4(q);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b4.valid_in = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (b4.packet_invalid !== (i == 3))
                $display("FAIL gap_pi idle=%0d got %b want %b", i, b4.packet_invalid, (i == 3));
            else passed++;
        end
        checks++; if (nv4 != 0 || b4.out_valid !== 1'b0) $display("FAIL gap_valid got %0d want 0", nv4); else passed++;
        send4(cat(make_u(U2_OLD, U2_NEW, U2_SH, U2_PR), zeros(1)));
        checks++; if (vb4 != 6) $display("FAIL gap_resync_beat got %0d want 6", vb4); else passed++;
        checks++; if (c_old !== U2_OLD) $display("FAIL gap_resync_old got %h want %h", c_old, U2_OLD); else passed++;
        checks++; if (c_pr !== U2_PR) $display("FAIL gap_resync_price got %h want %h", c_pr, U2_PR); else passed++;
        checks++; if (b4.replace_count !== 16'd1) $display("FAIL gap_cnt got %0d want 1", b4.replace_count); else passed++;
    endtask

    task automatic test_async_reset();
        bq_t u2, q;
        apply_reset();
        u2 = make_u(U2_OLD, U2_NEW, U2_SH, U2_PR);
        q = make_u(U1_OLD, U1_NEW, U1_SH, U1_PR);
        for (int i = 0; i < 9; i++) q.push_back(u2[i]);
        send4(q);
        checks++; if (b4.replace_count !== 16'd1) $display("FAIL ar_pre_cnt got %0d want 1", b4.replace_count); else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (b4.replace_count !== 16'd0) $display("FAIL ar_cnt got %0d want 0", b4.replace_count); else passed++;
        checks++; if (b4.old_order_ref !== 64'd0) $display("FAIL ar_old got %h want 0", b4.old_order_ref); else passed++;
        checks++; if (b4.shares !== 32'd0) $display("FAIL ar_shares got %h want 0", b4.shares); else passed++;
        checks++; if (b4.in_ready !== 1'b1) $display("FAIL ar_ready got %b want 1", b4.in_ready); else passed++;
        @(negedge clk);
        rst = 1'b1;
        nv4 = 0; vb4 = -1;
        send4(cat(u2, zeros(1)));
        checks++; if (nv4 != 1 || vb4 != 6) $display("FAIL ar_fresh got beat %0d want 6", vb4); else passed++;
        checks++; if (c_new !== U2_NEW) $display("FAIL ar_new got %h want %h", c_new, U2_NEW); else passed++;
        checks++; if (b4.replace_count !== 16'd1) $display("FAIL ar_fresh_cnt got %0d want 1", b4.replace_count); else passed++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send8(cat(cat(make_u(U1_OLD, U1_NEW, U1_SH, U1_PR), make_u(U2_OLD, U2_NEW, U2_SH, U2_PR)), zeros(2)),
              1'b1, U1_OLD);
        checks++; if (first8 != 3) $display("FAIL b2b_first got %0d want 3", first8); else passed++;
        checks++; if (stalls8 != 4) $display("FAIL b2b_stalls got %0d want 4", stalls8); else passed++;
        checks++; if (sec8 != 10) $display("FAIL b2b_second got %0d want 10", sec8); else passed++;
        checks++; if (c_old !== U2_OLD) $display("FAIL b2b_old got %h want %h", c_old, U2_OLD); else passed++;
        checks++; if (c_sh !== U2_SH) $display("FAIL b2b_shares got %h want %h", c_sh, U2_SH); else passed++;
        checks++; if (b8.replace_count !== 16'd2) $display("FAIL b2b_cnt got %0d want 2", b8.replace_count); else passed++;
    endtask

    task automatic test_gap_non_u();
        apply_reset();
        send8(make_msg(8'h41, 8), 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b8.valid_in = 1'b0;
            @(posedge clk);
            #1;
            if (b8.packet_invalid) npi8++;
        end
        checks++; if (npi8 != 0) $display("FAIL nonu_pi got %0d want 0", npi8); else passed++;
        send8(cat(make_u(U1_OLD, U1_NEW, U1_SH, U1_PR), zeros(5)), 1'b0, 64'd0);
        checks++; if (first8 != 3) $display("FAIL nonu_resync got %0d want 3", first8); else passed++;
        checks++; if (c_old !== U1_OLD) $display("FAIL nonu_old got %h want %h", c_old, U1_OLD); else passed++;
        checks++; if (b8.replace_count !== 16'd1) $display("FAIL nonu_cnt got %0d want 1", b8.replace_count); else passed++;
    endtask

    initial begin
        b4.data_in = '0; b4.valid_in = 1'b0; b4.out_ready = 1'b1;
        b8.data_in = '0; b8.valid_in = 1'b0; b8.out_ready = 1'b1;
        test_reset();
        test_single_u();
        test_mixed();
        test_gap_abort();
        test_async_reset();
        test_back_to_back();
        test_gap_non_u();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
